// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Multi-cycle control sequencer for the single-cycle datapath (register file,
// ALU-source mux, ALU). Accepts one RV32I instruction at a time over a
// valid/ready handshake, latches it into an instruction register and steps
// the datapath through FETCH / DECODE / EXEC / MEM / WB. Unsupported opcodes
// or funct3 encodings raise a sticky halt that only reset clears.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   instr        instruction word, captured on instr_valid && instr_ready
//   instr_valid  instruction source has a word
//   instr_ready  controller accepts a word (FETCH only)
//   EQ           ALU equality flag, used by branches in EXEC
//   mem_done     data memory finished the current access (MEM only)
//   rs1/rs2/rd   register addresses from the latched instruction
//   RegWrite     register-file write enable (suppressed when rd == 0)
//   ALUsrc       0 = register operand 2, 1 = ImmOp
//   ALUctrl      000 add, 001 sub, 010 and, 011 or, 101 slt
//   ImmOp        sign-extended immediate of the latched instruction
//   ResultSrc    write-back select: 00 ALU, 01 memory, 10 PC+4
//   mem_req      data-memory request
//   mem_we       data-memory write
//   PCen         one-cycle PC update strobe
//   PCsrc        00 PC+4, 01 PC+ImmOp, 10 ALUop1+ImmOp
//   halted       sticky illegal-instruction flag
//   state        current FSM state (debug)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int DATAWIDTH = 32,
    parameter int REGWIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic                 EQ,
    input  logic                 mem_done,
    output logic [REGWIDTH-1:0]  rs1,
    output logic [REGWIDTH-1:0]  rs2,
    output logic [REGWIDTH-1:0]  rd,
    output logic                 RegWrite,
    output logic                 ALUsrc,
    output logic [2:0]           ALUctrl,
    output logic [DATAWIDTH-1:0] ImmOp,
    output logic [1:0]           ResultSrc,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 PCen,
    output logic [1:0]           PCsrc,
    output logic                 halted,
    output logic [2:0]           state
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    // Legal opcode / funct3 combinations of the supported RV32I subset.
    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_R, OP_I: begin
                case (f3)
                    3'b000, 3'b111, 3'b110, 3'b010: ok = 1'b1;
                    default:                        ok = 1'b0;
                endcase
            end
            OP_LOAD, OP_STORE: ok = (f3 == 3'b010);
            OP_BRANCH:         ok = (f3 == 3'b000) || (f3 == 3'b001);
            OP_JAL:            ok = 1'b1;
            OP_JALR:           ok = (f3 == 3'b000);
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Immediate generator: format chosen by opcode, R-type has none.
    function automatic logic [DATAWIDTH-1:0] imm_gen(input logic [DATAWIDTH-1:0] ir);
        logic [DATAWIDTH-1:0] imm;
        case (ir[6:0])
            OP_I, OP_LOAD, OP_JALR:
                imm = {{(DATAWIDTH-12){ir[31]}}, ir[31:20]};
            OP_STORE:
                imm = {{(DATAWIDTH-12){ir[31]}}, ir[31:25], ir[11:7]};
            OP_BRANCH:
                imm = {{(DATAWIDTH-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            OP_JAL:
                imm = {{(DATAWIDTH-20){ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            default:
                imm = {DATAWIDTH{1'b0}};
        endcase
        return imm;
    endfunction

    // ALU operation from funct3; sub_sel is funct7[5] and only applies to R-type.
    function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub_sel);
        logic [2:0] ctl;
        case (f3)
            3'b000:  ctl = sub_sel ? 3'b001 : 3'b000;
            3'b111:  ctl = 3'b010;
            3'b110:  ctl = 3'b011;
            3'b010:  ctl = 3'b101;
            default: ctl = 3'b000;
        endcase
        return ctl;
    endfunction

    state_t                 state_r;
    state_t                 next_state_s;
    logic [DATAWIDTH-1:0]   ir_r;
    logic                   halted_r;

    logic [6:0]             op_s;
    logic [2:0]             f3_s;
    logic                   legal_s;
    logic                   handshake_s;

    logic                   ready_s;
    logic                   reg_write_s;
    logic                   alu_src_s;
    logic [2:0]             alu_ctrl_s;
    logic [1:0]             result_src_s;
    logic                   mem_req_s;
    logic                   mem_we_s;
    logic                   pc_en_s;
    logic [1:0]             pc_src_s;

    assign op_s        = ir_r[6:0];
    assign f3_s        = ir_r[14:12];
    assign legal_s     = is_legal(op_s, f3_s);
    assign handshake_s = instr_valid && (state_r == S_FETCH);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Instruction register, loaded on the fetch handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_r <= {DATAWIDTH{1'b0}};
        end else if (handshake_s) begin
            ir_r <= instr;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Sticky halt flag, set when DECODE finds an illegal instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_r <= 1'b0;
        end else if ((state_r == S_DECODE) && !legal_s) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (instr_valid) begin
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (legal_s) begin
                    next_state_s = S_EXEC;
                end else begin
                    next_state_s = S_HALT;
                end
            end
            S_EXEC: begin
                if ((op_s == OP_LOAD) || (op_s == OP_STORE)) begin
                    next_state_s = S_MEM;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_MEM: begin
                if (!mem_done) begin
                    next_state_s = S_MEM;
                end else if (op_s == OP_LOAD) begin
                    next_state_s = S_WB;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_WB:    next_state_s = S_FETCH;
            S_HALT:  next_state_s = S_HALT;
            default: next_state_s = S_FETCH;
        endcase
    end

    // Control outputs decoded from state, latched instruction and EQ.
    always_comb begin
        ready_s      = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_s    = 1'b0;
        alu_ctrl_s   = 3'b000;
        result_src_s = 2'b00;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        pc_en_s      = 1'b0;
        pc_src_s     = 2'b00;
        case (state_r)
            S_FETCH: ready_s = 1'b1;
            S_EXEC: begin
                case (op_s)
                    OP_R: begin
                        reg_write_s = 1'b1;
                        alu_ctrl_s  = alu_op(f3_s, ir_r[30]);
                        pc_en_s     = 1'b1;
                    end
                    OP_I: begin
                        reg_write_s = 1'b1;
                        alu_src_s   = 1'b1;
                        alu_ctrl_s  = alu_op(f3_s, 1'b0);
                        pc_en_s     = 1'b1;
                    end
                    OP_BRANCH: begin
                        alu_ctrl_s = 3'b001;
                        pc_en_s    = 1'b1;
                        // funct3[0] distinguishes bne from beq.
                        if (EQ ^ f3_s[0]) begin
                            pc_src_s = 2'b01;
                        end else begin
                            pc_src_s = 2'b00;
                        end
                    end
                    OP_JAL: begin
                        reg_write_s  = 1'b1;
                        result_src_s = 2'b10;
                        pc_en_s      = 1'b1;
                        pc_src_s     = 2'b01;
                    end
                    OP_JALR: begin
                        reg_write_s  = 1'b1;
                        result_src_s = 2'b10;
                        alu_src_s    = 1'b1;
                        pc_en_s      = 1'b1;
                        pc_src_s     = 2'b10;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_s  = 1'b1;
                        alu_ctrl_s = 3'b000;
                    end
                    default: begin
                        alu_src_s = 1'b0;
                    end
                endcase
            end
            S_MEM: begin
                // Address operands stay selected for the whole access.
                alu_src_s = 1'b1;
                mem_req_s = 1'b1;
                mem_we_s  = (op_s == OP_STORE);
                if (mem_done && (op_s == OP_STORE)) begin
                    pc_en_s = 1'b1;
                end else begin
                    pc_en_s = 1'b0;
                end
            end
            S_WB: begin
                reg_write_s  = 1'b1;
                result_src_s = 2'b01;
                pc_en_s      = 1'b1;
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    // Strobes are forced low while reset is held so a pending access or PC
    // update in the interrupted state never reaches the datapath.
    assign instr_ready = ready_s && !rst;
    assign RegWrite    = reg_write_s && (rd != {REGWIDTH{1'b0}}) && !rst;
    assign mem_req     = mem_req_s && !rst;
    assign mem_we      = mem_we_s && !rst;
    assign PCen        = pc_en_s && !rst;

    assign ALUsrc      = alu_src_s;
    assign ALUctrl     = alu_ctrl_s;
    assign ResultSrc   = result_src_s;
    assign PCsrc       = pc_src_s;

    assign rs1         = ir_r[19:15];
    assign rs2         = ir_r[24:20];
    assign rd          = ir_r[11:7];
    assign ImmOp       = imm_gen(ir_r);
    assign halted      = halted_r;
    assign state       = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. Each task drives one scenario and
// compares outputs with hand-computed values 2-3 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        EQ;
    logic        mem_done;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        RegWrite;
    logic        ALUsrc;
    logic [2:0]  ALUctrl;
    logic [31:0] ImmOp;
    logic [1:0]  ResultSrc;
    logic        mem_req;
    logic        mem_we;
    logic        PCen;
    logic [1:0]  PCsrc;
    logic        halted;
    logic [2:0]  state;

    int vec_cnt;
    int err_cnt;

    multicycle_ctrl #(.DATAWIDTH(32), .REGWIDTH(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .EQ          (EQ),
        .mem_done    (mem_done),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .RegWrite    (RegWrite),
        .ALUsrc      (ALUsrc),
        .ALUctrl     (ALUctrl),
        .ImmOp       (ImmOp),
        .ResultSrc   (ResultSrc),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .PCen        (PCen),
        .PCsrc       (PCsrc),
        .halted      (halted),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present a word in FETCH for one cycle; returns in DECODE.
    task automatic issue(input logic [31:0] word);
        instr       = word;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        if (instr_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_ready: got %0b want 0", instr_ready); end
        vec_cnt++;
        if (state !== 3'd0) begin err_cnt++; $display("FAIL rst_state: got %0d want 0", state); end
        vec_cnt++;
        if (halted !== 1'b0) begin err_cnt++; $display("FAIL rst_halted: got %0b want 0", halted); end
        vec_cnt++;
        if (ImmOp !== 32'h0 || rd !== 5'd0) begin err_cnt++; $display("FAIL rst_ir: ImmOp=%h rd=%0d want 0/0", ImmOp, rd); end
        vec_cnt++;
        if (PCen !== 1'b0 || mem_req !== 1'b0) begin err_cnt++; $display("FAIL rst_strobes: PCen=%0b mem_req=%0b want 0/0", PCen, mem_req); end
        vec_cnt++;
        rst = 1'b0;
        #1;
        if (instr_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_release_ready: got %0b want 1", instr_ready); end
        vec_cnt++;
    endtask

    task automatic test_addi();
        issue(32'h00700293);
        if (state !== 3'd1 || ImmOp !== 32'd7) begin err_cnt++; $display("FAIL addi_decode: state=%0d ImmOp=%h want 1/7", state, ImmOp); end
        vec_cnt++;
        if (PCen !== 1'b0 || RegWrite !== 1'b0) begin err_cnt++; $display("FAIL addi_decode_strobes: PCen=%0b RegWrite=%0b want 0/0", PCen, RegWrite); end
        vec_cnt++;
        tick();
        if (RegWrite !== 1'b1 || ALUsrc !== 1'b1 || ALUctrl !== 3'b000) begin
            err_cnt++; $display("FAIL addi_exec_ctl: RegWrite=%0b ALUsrc=%0b ALUctrl=%b want 1/1/000", RegWrite, ALUsrc, ALUctrl);
        end
        vec_cnt++;
        if (rd !== 5'd5 || PCen !== 1'b1 || PCsrc !== 2'b00 || ResultSrc !== 2'b00) begin
            err_cnt++; $display("FAIL addi_exec_pc: rd=%0d PCen=%0b PCsrc=%b ResultSrc=%b want 5/1/00/00", rd, PCen, PCsrc, ResultSrc);
        end
        vec_cnt++;
        tick();
        if (state !== 3'd0 || PCen !== 1'b0) begin err_cnt++; $display("FAIL addi_back_fetch: state=%0d PCen=%0b want 0/0", state, PCen); end
        vec_cnt++;
    endtask

    task automatic test_back_to_back();
        issue(32'h402081B3);
        if (rs1 !== 5'd1 || rs2 !== 5'd2) begin err_cnt++; $display("FAIL sub_decode_regs: rs1=%0d rs2=%0d want 1/2", rs1, rs2); end
        vec_cnt++;
        tick();
        if (ALUctrl !== 3'b001 || RegWrite !== 1'b1 || ALUsrc !== 1'b0 || PCen !== 1'b1) begin
            err_cnt++; $display("FAIL sub_exec: ALUctrl=%b RegWrite=%0b ALUsrc=%0b PCen=%0b want 001/1/0/1", ALUctrl, RegWrite, ALUsrc, PCen);
        end
        vec_cnt++;
        tick();
        if (instr_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready: got %0b want 1", instr_ready); end
        vec_cnt++;
        issue(32'h00100013);
        tick();
        if (RegWrite !== 1'b0 || PCen !== 1'b1) begin err_cnt++; $display("FAIL addi_x0_exec: RegWrite=%0b PCen=%0b want 0/1", RegWrite, PCen); end
        vec_cnt++;
        tick();
    endtask

    task automatic test_branch();
        logic [31:0] words [3];
        logic        eqs   [3];
        logic [1:0]  srcs  [3];
        words = '{32'h00208463, 32'h00208463, 32'h00209463};
        eqs   = '{1'b1, 1'b0, 1'b0};
        srcs  = '{2'b01, 2'b00, 2'b01};
        for (int i = 0; i < 3; i++) begin
            issue(words[i]);
            if (ImmOp !== 32'd8) begin err_cnt++; $display("FAIL br%0d_imm: got %h want 8", i, ImmOp); end
            vec_cnt++;
            EQ = eqs[i];
            tick();
            if (PCsrc !== srcs[i] || PCen !== 1'b1) begin
                err_cnt++; $display("FAIL br%0d_exec: PCsrc=%b PCen=%0b want %b/1", i, PCsrc, PCen, srcs[i]);
            end
            vec_cnt++;
            if (ALUctrl !== 3'b001 || ALUsrc !== 1'b0 || RegWrite !== 1'b0) begin
                err_cnt++; $display("FAIL br%0d_ctl: ALUctrl=%b ALUsrc=%0b RegWrite=%0b want 001/0/0", i, ALUctrl, ALUsrc, RegWrite);
            end
            vec_cnt++;
            tick();
            EQ = 1'b0;
        end
    endtask

    task automatic test_jal();
        issue(32'h010000EF);
        if (ImmOp !== 32'd16) begin err_cnt++; $display("FAIL jal_imm: got %h want 10", ImmOp); end
        vec_cnt++;
        tick();
        if (RegWrite !== 1'b1 || ResultSrc !== 2'b10 || PCsrc !== 2'b01 || PCen !== 1'b1) begin
            err_cnt++; $display("FAIL jal_exec: RegWrite=%0b ResultSrc=%b PCsrc=%b PCen=%0b want 1/10/01/1", RegWrite, ResultSrc, PCsrc, PCen);
        end
        vec_cnt++;
        tick();
    endtask

    task automatic test_lw();
        int req_cnt;
        int we_cnt;
        int pcen_cnt;
        int pcen_cyc;
        logic wb_ok;
        req_cnt = 0; we_cnt = 0; pcen_cnt = 0; pcen_cyc = 0; wb_ok = 1'b0;
        mem_done = 1'b0;
        issue(32'h0040A303);
        if (ImmOp !== 32'd4 || rd !== 5'd6) begin err_cnt++; $display("FAIL lw_decode: ImmOp=%h rd=%0d want 4/6", ImmOp, rd); end
        vec_cnt++;
        // Cycle 1 is DECODE; loop covers cycles 2..12 after the handshake.
        for (int c = 2; c <= 12; c++) begin
            tick();
            mem_done = (c == 6);
            #1;
            if (mem_req === 1'b1) req_cnt++;
            if (mem_we === 1'b1) we_cnt++;
            if (PCen === 1'b1) begin
                pcen_cnt++;
                pcen_cyc = c;
                wb_ok = (RegWrite === 1'b1) && (ResultSrc === 2'b01) && (PCsrc === 2'b00);
            end
        end
        mem_done = 1'b0;
        if (req_cnt !== 4) begin err_cnt++; $display("FAIL lw_req_cycles: got %0d want 4", req_cnt); end
        vec_cnt++;
        if (we_cnt !== 0) begin err_cnt++; $display("FAIL lw_we: got %0d cycles want 0", we_cnt); end
        vec_cnt++;
        if (pcen_cnt !== 1 || pcen_cyc !== 7) begin err_cnt++; $display("FAIL lw_pcen: count=%0d cycle=%0d want 1/7", pcen_cnt, pcen_cyc); end
        vec_cnt++;
        if (wb_ok !== 1'b1) begin err_cnt++; $display("FAIL lw_wb_ctl: got %0b want 1", wb_ok); end
        vec_cnt++;
    endtask

    task automatic test_sw();
        mem_done = 1'b0;
        issue(32'h0020A023);
        tick();
        if (ALUsrc !== 1'b1 || mem_req !== 1'b0) begin err_cnt++; $display("FAIL sw_exec: ALUsrc=%0b mem_req=%0b want 1/0", ALUsrc, mem_req); end
        vec_cnt++;
        mem_done = 1'b1;
        tick();
        if (state !== 3'd3 || mem_req !== 1'b1 || mem_we !== 1'b1 || PCen !== 1'b1 || PCsrc !== 2'b00) begin
            err_cnt++; $display("FAIL sw_mem_done: state=%0d req=%0b we=%0b PCen=%0b PCsrc=%b want 3/1/1/1/00", state, mem_req, mem_we, PCen, PCsrc);
        end
        vec_cnt++;
        tick();
        mem_done = 1'b0;
        if (state !== 3'd0) begin err_cnt++; $display("FAIL sw_back_fetch: state=%0d want 0", state); end
        vec_cnt++;
    endtask

    task automatic test_illegal();
        int bad;
        bad = 0;
        issue(32'h0000007F);
        if (halted !== 1'b0) begin err_cnt++; $display("FAIL ill_decode_halted: got %0b want 0", halted); end
        vec_cnt++;
        tick();
        if (halted !== 1'b1 || state !== 3'd7 || instr_ready !== 1'b0) begin
            err_cnt++; $display("FAIL ill_halt: halted=%0b state=%0d ready=%0b want 1/7/0", halted, state, instr_ready);
        end
        vec_cnt++;
        instr       = 32'h00700293;
        instr_valid = 1'b1;
        mem_done    = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (PCen !== 1'b0 || instr_ready !== 1'b0 || mem_req !== 1'b0 || state !== 3'd7) bad++;
        end
        instr_valid = 1'b0;
        mem_done    = 1'b0;
        if (bad !== 0) begin err_cnt++; $display("FAIL ill_stays_halted: %0d bad cycles want 0", bad); end
        vec_cnt++;
        rst = 1'b1;
        tick();
        if (halted !== 1'b0 || state !== 3'd0) begin err_cnt++; $display("FAIL ill_rst_clear: halted=%0b state=%0d want 0/0", halted, state); end
        vec_cnt++;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_sw_reset();
        int pc_seen;
        pc_seen = 0;
        mem_done = 1'b0;
        issue(32'h0020A023);
        tick();
        tick();
        if (mem_req !== 1'b1 || mem_we !== 1'b1) begin err_cnt++; $display("FAIL swr_mem: req=%0b we=%0b want 1/1", mem_req, mem_we); end
        vec_cnt++;
        tick();
        rst = 1'b1;
        #1;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || PCen !== 1'b0) begin
            err_cnt++; $display("FAIL swr_in_reset: req=%0b we=%0b PCen=%0b want 0/0/0", mem_req, mem_we, PCen);
        end
        vec_cnt++;
        mem_done = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        if (state !== 3'd0 || mem_req !== 1'b0) begin err_cnt++; $display("FAIL swr_after: state=%0d req=%0b want 0/0", state, mem_req); end
        vec_cnt++;
        for (int c = 0; c < 3; c++) begin
            if (PCen === 1'b1) pc_seen++;
            tick();
        end
        mem_done = 1'b0;
        if (pc_seen !== 0) begin err_cnt++; $display("FAIL swr_no_pcen: %0d strobes want 0", pc_seen); end
        vec_cnt++;
    endtask

    initial begin
        vec_cnt     = 0;
        err_cnt     = 0;
        rst         = 1'b1;
        instr       = 32'h0;
        instr_valid = 1'b0;
        EQ          = 1'b0;
        mem_done    = 1'b0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_branch();
        test_jal();
        test_lw();
        test_sw();
        test_illegal();
        test_sw_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the single-cycle datapath block (register file, ALU-source mux, ALU). It accepts one RV32I instruction at a time over a valid/ready handshake, decodes it, and steps the datapath through FETCH/DECODE/EXEC/MEM/WB. It drives register addresses, immediate, ALU controls, write-enable, memory strobes and PC-update controls. A sticky halt is raised on unsupported opcodes.

## Interface
- DATAWIDTH, 32, datapath and instruction width
- REGWIDTH, 5, register address width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr  in  DATAWIDTH  instruction word, sampled when instr_valid && instr_ready
- instr_valid  in  1  instruction source has a word
- instr_ready  out  1  controller accepts a word (FETCH state only)
- EQ  in  1  ALU equality flag from datapath
- mem_done  in  1  data memory completes the current access
- rs1, rs2, rd  out  REGWIDTH  register addresses from latched instruction
- RegWrite  out  1  register-file write enable
- ALUsrc  out  1  0 = regOp2, 1 = ImmOp
- ALUctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmOp  out  DATAWIDTH  sign-extended immediate
- ResultSrc  out  2  write-back select: 00 ALU, 01 memory, 10 PC+4
- mem_req, mem_we  out  1  data-memory request / write
- PCen  out  1  one-cycle PC update strobe
- PCsrc  out  2  00 PC+4, 01 PC+ImmOp, 10 ALUop1+ImmOp (jalr)
- halted  out  1  sticky illegal-instruction flag
- state  out  3  current FSM state (debug)

## Operation
- Supported opcodes:
  - 0110011 R-type: add/sub (funct7 bit 5), and, or, slt.
  - 0010011 I-ALU: addi, andi, ori, slti.
  - 0000011 lw.
  - 0100011 sw.
  - 1100011 beq/bne.
  - 1101111 jal.
  - 1100111 jalr.
  - Any other opcode or funct3 is illegal.
- The instruction register (IR) is loaded on the handshake. All outputs are combinational from state and IR, plus EQ for PCsrc/PCen.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- FETCH:
  - instr_ready=1.
  - On handshake, latch IR and go to DECODE. Otherwise stay.
- DECODE:
  - Drive rs1/rs2 and ImmOp (I/S/B/J format per opcode).
  - Illegal instruction: set halted and go to HALT. Otherwise go to EXEC.
- EXEC:
  - R/I-ALU: RegWrite=1, ResultSrc=00, PCen=1, PCsrc=00, then FETCH.
  - Branch: ALUctrl=001, ALUsrc=0, PCen=1. PCsrc=01 if taken (beq: EQ=1, bne: EQ=0), else 00. Then FETCH.
  - jal: RegWrite=1, ResultSrc=10, PCen=1, PCsrc=01, then FETCH.
  - jalr: RegWrite=1, ResultSrc=10, ALUsrc=1, PCen=1, PCsrc=10, then FETCH.
  - lw/sw: ALUsrc=1, ALUctrl=000 (address), then MEM.
- MEM:
  - mem_req=1, mem_we=1 for sw. ALU address inputs are held.
  - Wait for mem_done. Then sw: PCen=1, go to FETCH. lw: go to WB.
- WB: RegWrite=1, ResultSrc=01, PCen=1, PCsrc=00, then FETCH.
- HALT: all strobes 0 and instr_ready=0. Exit only via rst.
- rd==0: RegWrite is suppressed in every state.
- Outside the states that drive them, strobes and control outputs are 0.
- ImmOp is valid and stable from DECODE through the last cycle of the instruction.

## Timing
- Reset:
  - state=FETCH, IR=0, halted=0.
  - While rst=1: instr_ready, RegWrite, mem_req, mem_we and PCen are forced to 0.
- Reset mid-operation (any state, including MEM with mem_req high): the next cycle is FETCH. The pending access is dropped and no PCen is issued.
- Latency, handshake cycle to PCen:
  - ALU, branch, jal, jalr: 2 cycles (DECODE, EXEC).
  - sw: 3+N, where N is the number of cycles mem_done is low in MEM.
  - lw: 4+N.
- Back-to-back throughput: the next instruction is accepted in FETCH the cycle after the PCen cycle. This gives a minimum of 3 cycles per ALU instruction.
- Handshakes:
  - instr_valid may stay high across FETCH wait cycles. instr must be stable while valid && !ready.
  - mem_done is ignored outside MEM.
  - mem_done high in the first MEM cycle gives N=0.
- PCen is high for exactly one cycle per retired instruction and never in HALT.
- EQ is sampled combinationally in EXEC only.

## Test plan
- Reset, then addi x5,x0,7 (0x00700293) valid:
  - DECODE: ImmOp=7.
  - EXEC: RegWrite=1, ALUsrc=1, ALUctrl=000, rd=5, PCen=1.
  - Next cycle: FETCH.
- sub x3,x1,x2 (0x402081B3), then addi x0,x0,1:
  - sub EXEC: ALUctrl=001, RegWrite=1.
  - addi EXEC: RegWrite=0 because rd=0, PCen=1.
- beq x1,x2,+8 (0x00208463):
  - EQ=1: PCsrc=01, ImmOp=8, PCen=1.
  - Repeat with EQ=0: PCsrc=00.
  - bne 0x00209463 with EQ=0: PCsrc=01.
- lw x6,4(x1) (0x0040A303), mem_done low 3 cycles then high:
  - mem_req high 4 cycles, mem_we=0.
  - WB: RegWrite=1, ResultSrc=01.
  - PCen occurs 7 cycles after the handshake.
- Opcode 0x0000007F: halted=1 after DECODE. In HALT, instr_ready=0 and PCen is never asserted. rst clears halted.
- sw x2,0(x1) (0x0020A023) with mem_done held low, rst asserted in MEM:
  - mem_req and mem_we drop during reset.
  - state=FETCH after rst deasserts, no PCen.
